// File: rtl/bw_mult_pkg.sv
// Shared constants, clog2 helper and response record for the multiplier arbiter.
// The optional per-requester accept counters are enabled with BW_MULT_ARB_PERF_EN.
package bw_mult_pkg;
    localparam int BW_N_DEFAULT = 16;
    localparam int BW_R_DEFAULT = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    localparam int BW_IDW_DEFAULT = clog2(BW_R_DEFAULT);

    typedef struct packed {
        logic                          valid;
        logic [BW_IDW_DEFAULT-1:0]     id;
        logic [2*BW_N_DEFAULT-1:0]     p;
    } bw_resp_t;
endpackage

// File: rtl/bw_mult.sv
// Combinational signed N x N Baugh-Wooley multiplier producing a full 2N-bit product.
module bw_mult #(
    parameter int N = 16
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);
    logic [2*N-1:0] acc;
    logic           pp;

    // Partial products that mix exactly one sign bit are inverted; the two
    // correction constants 2^N and 2^(2N-1) restore the two's-complement sum.
    always_comb begin
        acc = '0;
        pp  = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pp = a_i[i] & b_i[j];
                if ((i == N-1) != (j == N-1)) pp = ~pp;
                acc = acc + ((2*N)'(pp) << (i + j));
            end
        end
        acc = acc + ((2*N)'(1) << N) + ((2*N)'(1) << (2*N-1));
    end

    assign p_o = acc;
endmodule

// File: rtl/bw_rr_arbiter.sv
// Combinational round-robin search: first requester at or after the pointer wins.
module bw_rr_arbiter #(
    parameter int R   = 4,
    parameter int IDW = 2
) (
    input  logic [R-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    input  logic           en_i,
    output logic [R-1:0]   grant_o,
    output logic [IDW-1:0] grant_idx_o
);
    logic found;
    int   idx;

    always_comb begin
        found       = 1'b0;
        idx         = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        for (int k = 0; k < R; k++) begin
            idx = (int'(ptr_i) + k) % R;
            if (!found && req_i[idx]) begin
                found       = 1'b1;
                grant_idx_o = IDW'(idx);
            end
        end
        if (found && en_i) grant_o[grant_idx_o] = 1'b1;
    end
endmodule

// File: rtl/bw_mult_arbiter.sv
// R requesters share one Baugh-Wooley multiplier through a 2-stage pipeline.
// Define BW_MULT_ARB_PERF_EN to add per-requester accept counters (perf_cnt/perf_clr).
module bw_mult_arbiter
    import bw_mult_pkg::*;
#(
    parameter int N   = BW_N_DEFAULT,
    parameter int R   = BW_R_DEFAULT,
    parameter int IDW = clog2(BW_R_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [R-1:0]     req_valid,
    output logic [R-1:0]     req_ready,
    input  logic [R*N-1:0]   req_a,
    input  logic [R*N-1:0]   req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [2*N-1:0]   resp_p,
    output logic [IDW-1:0]   resp_id,
`ifdef BW_MULT_ARB_PERF_EN
    input  logic             perf_clr,
    output logic [R*16-1:0]  perf_cnt,
`endif
    output logic             busy
);
    logic           v1_q, v1_d;
    logic [N-1:0]   a1_q, a1_d, b1_q, b1_d;
    logic [IDW-1:0] id1_q, id1_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           rv_q, rv_d;
    logic [2*N-1:0] rp_q, rp_d;
    logic [IDW-1:0] rid_q, rid_d;

    logic           stall2, stall1, accept;
    logic [R-1:0]   grant;
    logic [IDW-1:0] grant_idx;
    logic [2*N-1:0] product;

    assign stall2 = rv_q & ~resp_ready;
    assign stall1 = v1_q & stall2;

    // Ready is also held low while reset is asserted.
    bw_rr_arbiter #(.R(R), .IDW(IDW)) u_arb (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .en_i        (~stall1 & ~rst),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    bw_mult #(.N(N)) u_mult (
        .a_i (a1_q),
        .b_i (b1_q),
        .p_o (product)
    );

    assign accept = |grant;

    always_comb begin
        v1_d  = v1_q;
        a1_d  = a1_q;
        b1_d  = b1_q;
        id1_d = id1_q;
        ptr_d = ptr_q;
        rv_d  = rv_q;
        rp_d  = rp_q;
        rid_d = rid_q;
        if (!stall2) begin
            rv_d = v1_q;
            if (v1_q) begin
                rp_d  = product;
                rid_d = id1_q;
            end
            v1_d = 1'b0;
        end
        if (accept) begin
            v1_d  = 1'b1;
            a1_d  = req_a[grant_idx*N +: N];
            b1_d  = req_b[grant_idx*N +: N];
            id1_d = grant_idx;
            ptr_d = (int'(grant_idx) == R-1) ? '0 : grant_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            a1_q  <= '0;
            b1_q  <= '0;
            id1_q <= '0;
            ptr_q <= '0;
            rv_q  <= 1'b0;
            rp_q  <= '0;
            rid_q <= '0;
        end else begin
            v1_q  <= v1_d;
            a1_q  <= a1_d;
            b1_q  <= b1_d;
            id1_q <= id1_d;
            ptr_q <= ptr_d;
            rv_q  <= rv_d;
            rp_q  <= rp_d;
            rid_q <= rid_d;
        end
    end

    assign req_ready  = grant;
    assign resp_valid = rv_q;
    assign resp_p     = rp_q;
    assign resp_id    = rid_q;
    assign busy       = v1_q | rv_q;

`ifdef BW_MULT_ARB_PERF_EN
    logic [R*16-1:0] perf_q, perf_d;

    // Clear takes priority over a coincident accept.
    always_comb begin
        perf_d = perf_q;
        for (int i = 0; i < R; i++) begin
            if (grant[i]) perf_d[i*16 +: 16] = perf_q[i*16 +: 16] + 16'd1;
        end
        if (perf_clr) perf_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign perf_cnt = perf_q;
`endif
endmodule

// File: tb/tb_bw_mult_arbiter.sv
// Scoreboard bench for bw_mult_arbiter: random and directed traffic against a queue model.
module tb_bw_mult_arbiter;
    import bw_mult_pkg::*;

    localparam int N = 16;
    localparam int R = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [R-1:0]    req_valid = '0;
    logic [R-1:0]    req_ready;
    logic [R*N-1:0]  req_a = '0;
    logic [R*N-1:0]  req_b = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [2*N-1:0]  resp_p;
    logic [1:0]      resp_id;
    logic            busy;

    int checks_total  = 0;
    int checks_passed = 0;

    bw_resp_t exp_q[$];
    int       ptr_m = 0;

    bw_mult_arbiter #(.N(N), .R(R), .IDW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_p     (resp_p),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (ok) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Reference model: round-robin over valids from ptr_m, capacity of two in-flight
    // products, responses leave in acceptance order.
    logic [R-1:0]       exp_ready;
    int                 w;
    bit                 can_acc;
    bit                 held = 0;
    logic [31:0]        held_p;
    logic [1:0]         held_id;
    logic signed [15:0] ma, mb;
    logic signed [31:0] mp;
    bw_resp_t           ent;

    always @(negedge clk) begin
        if (rst) begin
            check(req_ready == '0, "ready_in_reset", req_ready, 0);
            held = 0;
        end else begin
            if (held)
                check(resp_valid && resp_p == held_p && resp_id == held_id, "stall_hold",
                      {resp_valid, resp_id, resp_p}, {1'b1, held_id, held_p});
            check(busy == (exp_q.size() != 0), "busy", busy, exp_q.size() != 0);
            can_acc = !(exp_q.size() == 2 && !resp_ready);
            w = -1;
            for (int k = 0; k < R; k++) begin
                if (w < 0 && req_valid[(ptr_m + k) % R]) w = (ptr_m + k) % R;
            end
            exp_ready = '0;
            if (w >= 0 && can_acc) exp_ready[w] = 1'b1;
            check(req_ready == exp_ready, "req_ready", req_ready, exp_ready);
            if (resp_valid) begin
                check(exp_q.size() != 0, "resp_unexpected", resp_p, 0);
                if (exp_q.size() != 0 && resp_ready) begin
                    ent = exp_q.pop_front();
                    check(resp_p == ent.p, "resp_p", resp_p, ent.p);
                    check(resp_id == ent.id, "resp_id", resp_id, ent.id);
                end
            end
            held    = resp_valid && !resp_ready;
            held_p  = resp_p;
            held_id = resp_id;
            if (w >= 0 && can_acc) begin
                ma = req_a[w*N +: N];
                mb = req_b[w*N +: N];
                mp = ma * mb;
                ent.valid = 1'b1;
                ent.id    = 2'(w);
                ent.p     = mp;
                exp_q.push_back(ent);
                ptr_m = (w + 1) % R;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(!busy && exp_q.size() == 0, "idle_timeout", busy, 0);
    endtask

    task automatic single(input int id, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_p);
        wait_idle();
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_a[id*N +: N] = a;
        req_b[id*N +: N] = b;
        resp_ready = 1'b1;
        @(negedge clk);
        check(req_ready == (4'b0001 << id), "single_ready", req_ready, 4'b0001 << id);
        @(posedge clk); #1;
        req_valid = '0;
        check(!resp_valid && busy, "single_s1", {resp_valid, busy}, 2'b01);
        @(posedge clk); #1;
        check(resp_valid, "single_valid", resp_valid, 1);
        check(resp_p == exp_p, "single_p", resp_p, exp_p);
        check(resp_id == 2'(id), "single_id", resp_id, id);
        @(posedge clk); #1;
        check(!busy && !resp_valid, "single_drain", {busy, resp_valid}, 0);
    endtask

    initial begin
        int acc_cnt;
        int n;
        // Reset state with all requesters asking: nothing may be granted.
        req_valid = '1;
        #1;
        check(!resp_valid && resp_p == '0 && resp_id == '0 && !busy && req_ready == '0,
              "reset_outputs", {req_ready, busy, resp_valid, resp_id, resp_p}, 0);
        repeat (3) @(posedge clk);
        #1;
        req_valid = '0;
        rst = 1'b0;

        single(2, 16'hFFFD, 16'h0005, 32'hFFFFFFF1);
        single(0, 16'h8000, 16'h8000, 32'h40000000);
        single(3, 16'h7FFF, 16'h8000, 32'hC0008000);

        // Fairness: pointer is back at 0 after the grant to requester 3.
        wait_idle();
        req_valid  = '1;
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < R; i++) begin
                req_a[i*N +: N] = rand_op();
                req_b[i*N +: N] = rand_op();
            end
            @(negedge clk);
            check(req_ready == (4'b0001 << (k % R)), "rr_order", req_ready, 4'b0001 << (k % R));
            @(posedge clk); #1;
        end
        req_valid = '0;

        // Backpressure: only two products fit while the consumer stalls.
        wait_idle();
        resp_ready = 1'b0;
        req_valid  = 4'b1010;
        acc_cnt    = 0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < R; i++) begin
                req_a[i*N +: N] = rand_op();
                req_b[i*N +: N] = rand_op();
            end
            @(negedge clk);
            if (|req_ready) acc_cnt++;
            @(posedge clk); #1;
        end
        check(acc_cnt == 2, "stall_accepts", acc_cnt, 2);
        req_valid  = '0;
        resp_ready = 1'b1;
        wait_idle();

        // Asynchronous reset with both stages full.
        req_valid  = '1;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check(resp_valid && busy, "pre_reset_full", {resp_valid, busy}, 2'b11);
        rst = 1'b1;
        exp_q.delete();
        ptr_m = 0;
        #1;
        check(!resp_valid && !busy && req_ready == '0, "async_reset", {req_ready, resp_valid, busy}, 0);
        req_valid  = 4'b1100;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check(req_ready == 4'b0100, "post_reset_grant", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            for (int i = 0; i < R; i++) begin
                req_a[i*N +: N] = rand_op();
                req_b[i*N +: N] = rand_op();
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(exp_q.size() == 0, "final_drain", exp_q.size(), 0);
        @(posedge clk); #1;
        check(!busy, "final_idle", busy, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
